iceboard_uart_frame_rx: RTL and testbench

- Receive-side front end for one iceboard serial link.
- Sits directly upstream of the iceboardcontrol core and is driven by the board pin that the system top exports as iceboardcontrol_N_conduit_end_rx.
- Deserialises 8N1 UART, hunts for a sync byte, assembles fixed-length frames and checks an XOR checksum.
- Hands each good frame (id + payload) to iceboardcontrol over a valid/ready handshake and keeps error counters for the HPS.

---
 rtl/iceboard_pkg.sv | 30 +++
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/iceboard_uart_frame_rx.sv | 133 +++++++++++++
 tb/tb_iceboard_uart_frame_rx.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iceboard_pkg.sv
// Shared types and helpers for the iceboard serial receive path.
// Used by the byte receiver and the frame assembler.
package iceboard_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_WAIT_HIGH
  } bit_state_t;

  typedef enum logic [1:0] {
    FR_HUNT,
    FR_ID,
    FR_PAYLOAD,
    FR_CHECK
  } frame_state_t;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop line synchroniser plus mid-bit sampling FSM.
// Pulses byte_strobe on a good stop bit and framing_err on a bad one.
module uart_rx_byte
  import iceboard_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_strobe,
  output logic [7:0] byte_data,
  output logic       framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic          sync0, sync1;
  logic [1:0]    fill;
  logic          armed;
  bit_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;

  // armed only rises once a genuine high has crossed the synchroniser, so a line
  // held low through reset release is not mistaken for a start bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      fill  <= '0;
      armed <= 1'b0;
      state <= BIT_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      sync0 <= rx;
      sync1 <= sync0;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & sync1);
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shift;
    byte_strobe = 1'b0;
    framing_err = 1'b0;
    case (state)
      BIT_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (armed && !sync1) state_n = BIT_START;
      end
      BIT_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = sync1 ? BIT_IDLE : BIT_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BIT_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          shift_n = {sync1, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = BIT_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BIT_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n = '0;
          if (sync1) begin
            byte_strobe = 1'b1;
            state_n     = BIT_IDLE;
          end else begin
            framing_err = 1'b1;
            state_n     = BIT_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BIT_WAIT_HIGH: begin
        if (sync1) state_n = BIT_IDLE;
      end
      default: state_n = BIT_IDLE;
    endcase
  end

  assign byte_data = shift;

endmodule

// File: rtl/iceboard_uart_frame_rx.sv
// Receive front end for one iceboard link: sync hunt, fixed-length frame assembly,
// XOR checksum, valid/ready output hold and saturating error counters.
module iceboard_uart_frame_rx
  import iceboard_pkg::*;
#(
  parameter int         CLK_FREQ_HZ   = 50000000,
  parameter int         BAUD          = 1000000,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         TIMEOUT_BITS  = 20
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       rx,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [7:0]                 frame_id,
  output logic [8*PAYLOAD_BYTES-1:0] frame_payload,
  output logic [15:0]                framing_err_cnt,
  output logic [15:0]                checksum_err_cnt,
  output logic [15:0]                overrun_cnt,
  output logic [15:0]                timeout_cnt
);

  localparam int CLKS_PER_BIT   = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW             = 8 * PAYLOAD_BYTES;

  if (CLKS_PER_BIT < 8 || (CLK_FREQ_HZ % BAUD) != 0) begin : g_baud_check
    $error("CLK_FREQ_HZ/BAUD must be an integer of at least 8");
  end
  if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 8) begin : g_payload_check
    $error("PAYLOAD_BYTES must be in 1..8");
  end

  logic          byte_strobe, framing_err;
  logic [7:0]    byte_data;
  frame_state_t  state, state_n;
  logic [7:0]    id_q, xor_q;
  logic [PW-1:0] payload_q;
  logic [3:0]    byte_cnt;
  logic [TW-1:0] timer;
  logic          load_id, take_payload, good_frame, bad_cksum, timed_out;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .byte_strobe (byte_strobe),
    .byte_data   (byte_data),
    .framing_err (framing_err)
  );

  // a sync value seen after HUNT is ordinary data; only errors and timeouts resync
  always_comb begin
    state_n      = state;
    load_id      = 1'b0;
    take_payload = 1'b0;
    good_frame   = 1'b0;
    bad_cksum    = 1'b0;
    timed_out    = 1'b0;
    if (framing_err) begin
      state_n = FR_HUNT;
    end else if (byte_strobe) begin
      case (state)
        FR_HUNT: if (byte_data == SYNC_BYTE) state_n = FR_ID;
        FR_ID: begin
          load_id = 1'b1;
          state_n = FR_PAYLOAD;
        end
        FR_PAYLOAD: begin
          take_payload = 1'b1;
          if (byte_cnt == 4'(PAYLOAD_BYTES - 1)) state_n = FR_CHECK;
        end
        FR_CHECK: begin
          state_n = FR_HUNT;
          if (byte_data == xor_q) good_frame = 1'b1;
          else bad_cksum = 1'b1;
        end
        default: state_n = FR_HUNT;
      endcase
    end else if (state != FR_HUNT && timer == TW'(TIMEOUT_CYCLES - 1)) begin
      timed_out = 1'b1;
      state_n   = FR_HUNT;
    end
  end

  // payload shifts in from the top so the first byte ends up in bits [7:0];
  // a completing frame may load on the same edge that the held one transfers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= FR_HUNT;
      id_q             <= '0;
      xor_q            <= '0;
      payload_q        <= '0;
      byte_cnt         <= '0;
      timer            <= '0;
      frame_valid      <= 1'b0;
      frame_id         <= '0;
      frame_payload    <= '0;
      framing_err_cnt  <= '0;
      checksum_err_cnt <= '0;
      overrun_cnt      <= '0;
      timeout_cnt      <= '0;
    end else begin
      state <= state_n;
      timer <= (state == FR_HUNT || byte_strobe || timed_out) ? '0 : timer + TW'(1);
      if (load_id) begin
        id_q     <= byte_data;
        xor_q    <= byte_data;
        byte_cnt <= '0;
      end
      if (take_payload) begin
        payload_q <= PW'({byte_data, payload_q} >> 8);
        xor_q     <= xor_q ^ byte_data;
        byte_cnt  <= byte_cnt + 4'd1;
      end
      if (good_frame && (!frame_valid || frame_ready)) begin
        frame_valid   <= 1'b1;
        frame_id      <= id_q;
        frame_payload <= payload_q;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (good_frame && frame_valid && !frame_ready) overrun_cnt <= sat_inc(overrun_cnt);
      if (framing_err) framing_err_cnt <= sat_inc(framing_err_cnt);
      if (bad_cksum) checksum_err_cnt <= sat_inc(checksum_err_cnt);
      if (timed_out) timeout_cnt <= sat_inc(timeout_cnt);
    end
  end

endmodule

// File: tb/tb_iceboard_uart_frame_rx.sv
// Scenario bench for iceboard_uart_frame_rx: drives a serial line bit by bit and
// checks delivered frames and counters against a frame-level expectation model.
module tb_iceboard_uart_frame_rx;

  localparam int CLK_HZ  = 24000000;
  localparam int BAUD    = 1000000;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int PB      = 4;
  localparam int TO_BITS = 20;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            rx;
  logic            frame_ready;
  logic            frame_valid;
  logic [7:0]      frame_id;
  logic [8*PB-1:0] frame_payload;
  logic [15:0]     framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0]     exp_fe, exp_ck, exp_ov, exp_to;
  logic [8*PB+7:0] exp_q[$];
  logic [8*PB+7:0] obs_q[$];
  logic [8*PB+7:0] got, want;

  always #5 clock = ~clock;

  iceboard_uart_frame_rx #(
    .CLK_FREQ_HZ   (CLK_HZ),
    .BAUD          (BAUD),
    .SYNC_BYTE     (8'hA5),
    .PAYLOAD_BYTES (PB),
    .TIMEOUT_BITS  (TO_BITS)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rx               (rx),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .frame_id         (frame_id),
    .frame_payload    (frame_payload),
    .framing_err_cnt  (framing_err_cnt),
    .checksum_err_cnt (checksum_err_cnt),
    .overrun_cnt      (overrun_cnt),
    .timeout_cnt      (timeout_cnt)
  );

  // every accepted transfer is recorded, sampled half a cycle away from the edge
  always @(negedge clock) begin
    if (reset_n && frame_valid && frame_ready) obs_q.push_back({frame_id, frame_payload});
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_ok;
    wait_cycles(CPB);
    rx = 1'b1;
    if (!stop_ok) wait_cycles(2 * CPB);
  endtask

  // checksum is the XOR of id and every payload byte; mask != 0 corrupts it
  task automatic send_frame(input logic [7:0] id, input logic [8*PB-1:0] pl, input logic [7:0] mask);
    logic [7:0] ck;
    ck = id;
    send_byte(8'hA5, 1'b1);
    send_byte(id, 1'b1);
    for (int i = 0; i < PB; i++) begin
      ck = ck ^ pl[8*i +: 8];
      send_byte(pl[8*i +: 8], 1'b1);
    end
    send_byte(ck ^ mask, 1'b1);
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    rx          = 1'b1;
    frame_ready = 1'b0;
    exp_fe = '0; exp_ck = '0; exp_ov = '0; exp_to = '0;
    wait_cycles(3);
    n_cmp++;
    if ({frame_valid, frame_id, frame_payload} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {frame_valid, frame_id, frame_payload});
    end
    n_cmp++;
    if ({framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_counters: got %h expected 0",
               {framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt});
    end
    reset_n = 1'b1;
    wait_cycles(4 * CPB);
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle_valid: got %b expected 0", frame_valid);
    end
  endtask

  task automatic test_clean_frame();
    logic [7:0] bytes [7];
    bytes = '{8'hA5, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h43};  // 07^11^22^33^44 = 43
    frame_ready = 1'b1;
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    wait_cycles(CPB);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL clean_count: got %0d expected 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_cmp++;
      if (got !== {8'h07, 32'h44332211}) begin
        n_fail++;
        $display("[TB] FAIL clean_frame: got %h expected %h", got, {8'h07, 32'h44332211});
      end
    end
    n_cmp++;
    if ({frame_valid, framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt} !== 65'h0) begin
      n_fail++;
      $display("[TB] FAIL clean_after: got %h expected 0",
               {frame_valid, framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt});
    end
    obs_q.delete();
  endtask

  task automatic test_bad_checksum();
    logic [7:0] bytes [7];
    logic [8*PB-1:0] pl;
    bytes = '{8'hA5, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    exp_ck++;
    wait_cycles(CPB);
    n_cmp++;
    if (obs_q.size() != 0 || checksum_err_cnt !== exp_ck) begin
      n_fail++;
      $display("[TB] FAIL bad_cksum: got frames=%0d cnt=%0d expected frames=0 cnt=%0d",
               obs_q.size(), checksum_err_cnt, exp_ck);
    end
    pl = $urandom;
    send_frame(8'h33, pl, 8'h00);
    exp_q.push_back({8'h33, pl});
    wait_cycles(CPB);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL bad_cksum_next_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL bad_cksum_next: got %h expected %h", got, want);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_framing_error();
    logic [8*PB-1:0] pl;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    exp_fe++;
    n_cmp++;
    if (framing_err_cnt !== exp_fe || obs_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL framing_err: got cnt=%0d frames=%0d expected cnt=%0d frames=0",
               framing_err_cnt, obs_q.size(), exp_fe);
    end
    pl = $urandom;
    send_frame(8'h0B, pl, 8'h00);
    wait_cycles(CPB);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL framing_next_count: got %0d expected 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      n_cmp++;
      if (got !== {8'h0B, pl}) begin
        n_fail++;
        $display("[TB] FAIL framing_next: got %h expected %h", got, {8'h0B, pl});
      end
    end
    n_cmp++;
    if ({framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt} !== {exp_fe, exp_ck, exp_ov, exp_to}) begin
      n_fail++;
      $display("[TB] FAIL framing_counters: got %h expected %h",
               {framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt}, {exp_fe, exp_ck, exp_ov, exp_to});
    end
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [8*PB-1:0] pl1, pl2;
    pl1 = $urandom;
    pl2 = $urandom;
    frame_ready = 1'b0;
    send_frame(8'h01, pl1, 8'h00);
    wait_cycles(CPB);
    n_cmp++;
    if (frame_valid !== 1'b1 || frame_id !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL bp_first: got valid=%b id=%h expected valid=1 id=01", frame_valid, frame_id);
    end
    send_frame(8'h02, pl2, 8'h00);
    exp_ov++;
    wait_cycles(CPB);
    n_cmp++;
    if ({frame_valid, frame_id, frame_payload, overrun_cnt} !== {1'b1, 8'h01, pl1, exp_ov}) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: got %h expected %h",
               {frame_valid, frame_id, frame_payload, overrun_cnt}, {1'b1, 8'h01, pl1, exp_ov});
    end
    frame_ready = 1'b1;
    wait_cycles(3);
    n_cmp++;
    if (frame_valid !== 1'b0 || obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got valid=%b transfers=%0d expected valid=0 transfers=1",
               frame_valid, obs_q.size());
    end
    if (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_cmp++;
      if (got !== {8'h01, pl1}) begin
        n_fail++;
        $display("[TB] FAIL bp_transfer: got %h expected %h", got, {8'h01, pl1});
      end
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    logic [8*PB-1:0] pl;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h11, 1'b1);
    wait_cycles(25 * CPB);
    exp_to++;
    n_cmp++;
    if (timeout_cnt !== exp_to || obs_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL timeout: got cnt=%0d frames=%0d expected cnt=%0d frames=0",
               timeout_cnt, obs_q.size(), exp_to);
    end
    pl = $urandom;
    send_frame(8'h06, pl, 8'h00);
    wait_cycles(CPB);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL timeout_next_count: got %0d expected 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      n_cmp++;
      if (got !== {8'h06, pl}) begin
        n_fail++;
        $display("[TB] FAIL timeout_next: got %h expected %h", got, {8'h06, pl});
      end
    end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_cycles(10);
    rx = 1'b1;
    wait_cycles(3 * CPB);
    n_cmp++;
    if ({framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt} !== {exp_fe, exp_ck, exp_ov, exp_to}
        || obs_q.size() != 0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch: got cnts=%h frames=%0d valid=%b expected cnts=%h frames=0 valid=0",
               {framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt}, obs_q.size(), frame_valid,
               {exp_fe, exp_ck, exp_ov, exp_to});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8*PB-1:0] pl;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    wait_cycles(3 * CPB);
    reset_n = 1'b0;
    exp_fe = '0; exp_ck = '0; exp_ov = '0; exp_to = '0;
    wait_cycles(2);
    n_cmp++;
    if ({frame_valid, frame_id, frame_payload, framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {frame_valid, frame_id, frame_payload, framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt});
    end
    reset_n = 1'b1;
    wait_cycles(12 * CPB);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    n_cmp++;
    if (framing_err_cnt !== 16'h0 || obs_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL low_at_release: got fe=%0d frames=%0d expected fe=0 frames=0",
               framing_err_cnt, obs_q.size());
    end
    pl = $urandom;
    send_frame(8'h0C, pl, 8'h00);
    wait_cycles(CPB);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL midreset_next_count: got %0d expected 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      n_cmp++;
      if (got !== {8'h0C, pl}) begin
        n_fail++;
        $display("[TB] FAIL midreset_next: got %h expected %h", got, {8'h0C, pl});
      end
    end
    obs_q.delete();
  endtask

  // random frames, some with corrupted checksum and some preceded by a stray byte
  task automatic test_random_frames();
    logic [7:0]      id, mask, stray;
    logic [8*PB-1:0] pl;
    frame_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      id   = 8'($urandom);
      pl   = $urandom;
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 2) == 0) begin
        stray = 8'($urandom);
        if (stray == 8'hA5) stray = 8'h5A;
        send_byte(stray, 1'b1);
      end
      send_frame(id, pl, mask);
      if (mask == 8'h00) exp_q.push_back({id, pl});
      else exp_ck++;
      wait_cycles($urandom_range(1, 3 * CPB));
    end
    wait_cycles(CPB);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL random_frame: got %h expected %h", got, want);
      end
    end
    n_cmp++;
    if ({framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt} !== {exp_fe, exp_ck, exp_ov, exp_to}) begin
      n_fail++;
      $display("[TB] FAIL random_counters: got %h expected %h",
               {framing_err_cnt, checksum_err_cnt, overrun_cnt, timeout_cnt}, {exp_fe, exp_ck, exp_ov, exp_to});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_bad_checksum();
    test_framing_error();
    test_backpressure();
    test_timeout();
    test_glitch();
    test_random_frames();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
